// File: rtl/game_seq_ctrl.sv
// Game sequencer: pause edge detect, game-tick divider, IDLE/RUN/PAUSE/CAUGHT control and BCD catch score.
// Every output is registered (one cycle from inputs); no backpressure, move/respawn are fire-and-forget pulses.
module game_seq_ctrl #(
    parameter int TICK_DIV   = 4,
    parameter int HOLD_TICKS = 2,
    parameter int PW         = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pause,
    input  logic [PW-1:0] cat_x,
    input  logic [PW-1:0] cat_y,
    input  logic [PW-1:0] mouse_x,
    input  logic [PW-1:0] mouse_y,
    output logic [1:0]    state,
    output logic          move_mouse,
    output logic          move_cat,
    output logic          respawn,
    output logic [15:0]   score
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSE  = 2'd2;
    localparam logic [1:0] S_CAUGHT = 2'd3;

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    logic          pause_q;
    logic [TW-1:0] tick_cnt;
    logic          parity;
    logic [HW-1:0] hold_cnt;

    logic          press;
    logic          collide;
    logic          wrap;
    logic [TW-1:0] tick_inc;

    logic [1:0]    state_nxt;
    logic [TW-1:0] tick_nxt;
    logic          parity_nxt;
    logic [HW-1:0] hold_nxt;
    logic [15:0]   score_nxt;
    logic          move_mouse_nxt;
    logic          move_cat_nxt;
    logic          respawn_nxt;

    // Four-digit BCD increment that sticks at 9999 instead of rolling over.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign press    = pause & ~pause_q;
    assign collide  = (cat_x == mouse_x) && (cat_y == mouse_y);
    assign wrap     = (tick_cnt == TICK_LAST);
    assign tick_inc = wrap ? '0 : tick_cnt + TW'(1);

    always_comb begin
        state_nxt      = state;
        tick_nxt       = tick_cnt;
        parity_nxt     = parity;
        hold_nxt       = hold_cnt;
        score_nxt      = score;
        move_mouse_nxt = 1'b0;
        move_cat_nxt   = 1'b0;
        respawn_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (press) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                tick_nxt = tick_inc;
                // Collision wins over a press and swallows any tick wrap this cycle.
                if (collide) begin
                    state_nxt = S_CAUGHT;
                    score_nxt = bcd_inc(score);
                    hold_nxt  = '0;
                end else if (press) begin
                    state_nxt = S_PAUSE;
                    tick_nxt  = tick_cnt;
                end else if (wrap) begin
                    move_mouse_nxt = 1'b1;
                    move_cat_nxt   = parity;
                    parity_nxt     = ~parity;
                end
            end

            S_PAUSE: begin
                if (press) begin
                    state_nxt = S_RUN;
                end
            end

            S_CAUGHT: begin
                tick_nxt = tick_inc;
                if (wrap) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt   = S_RUN;
                        respawn_nxt = 1'b1;
                        tick_nxt    = '0;
                        parity_nxt  = 1'b0;
                        hold_nxt    = '0;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // pause_q comes out of reset high so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            parity     <= 1'b0;
            hold_cnt   <= '0;
            score      <= 16'h0000;
            pause_q    <= 1'b1;
            move_mouse <= 1'b0;
            move_cat   <= 1'b0;
            respawn    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            parity     <= parity_nxt;
            hold_cnt   <= hold_nxt;
            score      <= score_nxt;
            pause_q    <= pause;
            move_mouse <= move_mouse_nxt;
            move_cat   <= move_cat_nxt;
            respawn    <= respawn_nxt;
        end
    end

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Bench for game_seq_ctrl: directed scenarios plus random stimulus against a game-rule reference model.
module tb_game_seq_ctrl;
    localparam int TD = 4;
    localparam int HT = 2;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pause;
    logic [PW-1:0] cat_x, cat_y, mouse_x, mouse_y;
    logic [1:0]    state;
    logic          move_mouse, move_cat, respawn;
    logic [15:0]   score;

    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: cycles into the current tick, ticks since (re)start, hold ticks, catch count.
    int   m_state, m_phase, m_ticks, m_hold, m_catches;
    logic m_prevp;
    logic exp_mm, exp_mc, exp_rs;

    game_seq_ctrl #(.TICK_DIV(TD), .HOLD_TICKS(HT), .PW(PW)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .pause      (pause),
        .cat_x      (cat_x),
        .cat_y      (cat_y),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .state      (state),
        .move_mouse (move_mouse),
        .move_cat   (move_cat),
        .respawn    (respawn),
        .score      (score)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic press, coll;
        exp_mm = 1'b0;
        exp_mc = 1'b0;
        exp_rs = 1'b0;
        if (!rst_n) begin
            m_state = 0; m_phase = 0; m_ticks = 0; m_hold = 0; m_catches = 0; m_prevp = 1'b1;
            return;
        end
        press   = pause && !m_prevp;
        m_prevp = pause;
        coll    = (cat_x == mouse_x) && (cat_y == mouse_y);
        case (m_state)
            0: if (press) m_state = 1;
            1: begin
                if (coll) begin
                    m_state = 3; m_catches++; m_hold = 0; m_phase = (m_phase + 1) % TD;
                end else if (press) begin
                    m_state = 2;
                end else begin
                    m_phase = (m_phase + 1) % TD;
                    if (m_phase == 0) begin
                        m_ticks++;
                        exp_mm = 1'b1;
                        exp_mc = (m_ticks % 2 == 0);
                    end
                end
            end
            2: if (press) m_state = 1;
            default: begin
                m_phase = (m_phase + 1) % TD;
                if (m_phase == 0) begin
                    m_hold++;
                    if (m_hold == HT) begin
                        m_state = 1; exp_rs = 1'b1; m_ticks = 0; m_hold = 0;
                    end
                end
            end
        endcase
    endtask

    function automatic logic [20:0] exp_vec();
        int          s;
        logic [15:0] b;
        s = (m_catches > 9999) ? 9999 : m_catches;
        b = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
        return {2'(m_state), b, exp_mm, exp_mc, exp_rs};
    endfunction

    function automatic logic [20:0] obs_vec();
        return {state, score, move_mouse, move_cat, respawn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic set_apart();
        cat_x = 6'd1; cat_y = 6'd1; mouse_x = 6'd10; mouse_y = 6'd20;
    endtask

    task automatic set_catch();
        cat_x = 6'd5; cat_y = 6'd7; mouse_x = 6'd5; mouse_y = 6'd7;
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst_n = 1'b0; pause = 1'b0; set_apart();
        for (int i = 0; i < 10; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL reset_hold: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL idle_model: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
            if (move_mouse || move_cat || respawn) pulses++;
        end
        n_total++;
        if (state !== 2'd0 || score !== 16'h0000 || pulses != 0)
            $display("FAIL idle_quiet: state=%0d score=%h pulses=%0d want 0/0000/0", state, score, pulses);
        else n_pass++;
    endtask

    task automatic test_run_ticks();
        int         seen = 0;
        logic [5:0] cats = '0;
        bit         gaps_ok = 1'b1;
        pause = 1'b1; step(); pause = 1'b0;
        n_total++;
        if (state !== 2'd1) $display("FAIL press_start: state=%0d want 1", state); else n_pass++;
        for (int i = 1; i <= 40 && seen < 6; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL run_model: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
            if (move_mouse === 1'b1) begin
                if (i != 4 * (seen + 1)) gaps_ok = 1'b0;
                cats[seen] = move_cat;
                seen++;
            end
        end
        n_total++;
        if (seen != 6 || !gaps_ok || cats !== 6'b101010)
            $display("FAIL run_cadence: pulses=%0d gaps_ok=%0d cat_bits=%b want 6/1/101010", seen, gaps_ok, cats);
        else n_pass++;
    endtask

    task automatic test_catch();
        int n = -1;
        for (int i = 0; i < TD && m_phase != TD - 1; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL catch_align: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
        end
        set_catch(); step(); set_apart();
        n_total++;
        if (state !== 2'd3 || score !== 16'h0001 || move_mouse !== 1'b0 || move_cat !== 1'b0)
            $display("FAIL catch_enter: state=%0d score=%h mm=%b mc=%b want 3/0001/0/0", state, score, move_mouse, move_cat);
        else n_pass++;
        for (int i = 1; i <= 20; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL catch_hold: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
            if (respawn === 1'b1) begin
                n = i;
                break;
            end
        end
        n_total++;
        if (n != 8 || state !== 2'd1) $display("FAIL respawn_time: cycles=%0d state=%0d want 8/1", n, state); else n_pass++;
        step(); n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL respawn_single: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
    endtask

    task automatic test_pause();
        int pulses = 0;
        int n = -1;
        for (int i = 0; i < TD && m_phase != 2; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL pause_align: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
        end
        pause = 1'b1; step(); pause = 1'b0;
        n_total++;
        if (state !== 2'd2) $display("FAIL pause_enter: state=%0d want 2", state); else n_pass++;
        for (int i = 0; i < 50; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL pause_model: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
            if (move_mouse || move_cat || respawn) pulses++;
        end
        n_total++;
        if (pulses != 0 || state !== 2'd2) $display("FAIL pause_frozen: pulses=%0d state=%0d want 0/2", pulses, state); else n_pass++;
        pause = 1'b1; step(); pause = 1'b0;
        n_total++;
        if (state !== 2'd1) $display("FAIL pause_resume: state=%0d want 1", state); else n_pass++;
        for (int i = 1; i <= 10; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL resume_model: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
            if (move_mouse === 1'b1) begin
                n = i;
                break;
            end
        end
        n_total++;
        if (n != 2) $display("FAIL resume_first_move: cycles=%0d want 2", n); else n_pass++;
        step(); step();
        set_catch(); pause = 1'b1; step(); pause = 1'b0; set_apart();
        n_total++;
        if (state !== 2'd3) $display("FAIL catch_over_press: state=%0d want 3", state); else n_pass++;
        for (int i = 0; i < 20 && m_state != 1; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL catch2_hold: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
        end
    endtask

    task automatic test_score_rollover();
        for (int k = 0; k < 200 && m_catches < 99; k++) begin
            set_catch(); step(); set_apart();
            n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL preload_catch: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
            for (int i = 0; i < 20 && m_state != 1; i++) begin
                step(); n_total++;
                if (obs_vec() !== exp_vec()) $display("FAIL preload_hold: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
            end
        end
        n_total++;
        if (score !== 16'h0099) $display("FAIL score_0099: score=%h want 0099", score); else n_pass++;
        set_catch(); step(); set_apart();
        n_total++;
        if (score !== 16'h0100) $display("FAIL score_carry: score=%h want 0100", score); else n_pass++;
        for (int i = 0; i < 20 && m_state != 1; i++) step();

        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        force dut.score = 16'h9998;
        m_catches = 9998;
        step(); step();
        release dut.score;
        step(); n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL score_preset: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
        pause = 1'b1; step(); pause = 1'b0;
        set_catch(); step(); set_apart();
        n_total++;
        if (score !== 16'h9999) $display("FAIL score_9999: score=%h want 9999", score); else n_pass++;
        for (int i = 0; i < 20 && m_state != 1; i++) step();
        set_catch(); step(); set_apart();
        n_total++;
        if (score !== 16'h9999 || state !== 2'd3) $display("FAIL score_saturate: score=%h state=%0d want 9999/3", score, state); else n_pass++;
        for (int i = 0; i < 20 && m_state != 1; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL sat_hold: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
        end
    endtask

    task automatic test_reset_cases();
        int rsp = 0;
        pause = 1'b1; rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL held_pause_model: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
        end
        n_total++;
        if (state !== 2'd0) $display("FAIL held_pause_idle: state=%0d want 0", state); else n_pass++;
        pause = 1'b0; step(); pause = 1'b1; step(); pause = 1'b0;
        set_catch(); step(); set_apart();
        n_total++;
        if (state !== 2'd3) $display("FAIL caught_before_reset: state=%0d want 3", state); else n_pass++;
        step(); step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_total++;
        if (state !== 2'd0 || score !== 16'h0000 || respawn !== 1'b0)
            $display("FAIL reset_in_caught: state=%0d score=%h respawn=%b want 0/0000/0", state, score, respawn);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL post_reset_model: dut=%h model=%h", obs_vec(), exp_vec()); else n_pass++;
            if (respawn === 1'b1) rsp++;
        end
        n_total++;
        if (rsp != 0 || state !== 2'd0) $display("FAIL post_reset_quiet: respawns=%0d state=%0d want 0/0", rsp, state); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_n   = ($urandom_range(0, 249) != 0);
            pause   = ($urandom_range(0, 5) == 0);
            cat_x   = PW'($urandom_range(0, 1));
            cat_y   = PW'($urandom_range(0, 1));
            mouse_x = PW'($urandom_range(0, 1));
            mouse_y = PW'($urandom_range(0, 1));
            step(); n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL random_model: cycle=%0d dut=%h model=%h", i, obs_vec(), exp_vec()); else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_run_ticks();
        test_catch();
        test_pause();
        test_score_rollover();
        test_reset_cases();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
